pico_memory_ctrl: RTL and testbench
===================================

# pico_memory_ctrl

Parametrised successor to the PicoComputer word memory: a synchronous single-port RAM with a request/ready handshake, configurable read latency (1 or 2), and a sequential clear engine. The clear engine zeroes a configurable low-address range after reset or on demand. The block sits between the CPU's memory-access stage and the RAM array. It replaces the combinational-read memory: the CPU issues requests and waits for rvalid instead of sampling out in the same cycle.

## Interface
- FILE_NAME, "mem_init.mif", power-up contents of the array (FPGA init file)
- ADDR_WIDTH, 6, word address width; depth = 2**ADDR_WIDTH
- DATA_WIDTH, 16, word width
- CLEAR_WORDS, 8, words zeroed by the clear sweep, starting at address 0; legal range 0..2**ADDR_WIDTH; 0 disables the sweep
- READ_LATENCY, 1, cycles from accepted read to rvalid; legal values 1 or 2

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req  in  1  access request
- we  in  1  1 = write, 0 = read; qualified by req
- addr  in  ADDR_WIDTH  word address
- wdata  in  DATA_WIDTH  write data
- ready  out  1  request accepted this cycle when req && ready
- rvalid  out  1  rdata valid, one-cycle pulse per accepted read
- rdata  out  DATA_WIDTH  read data
- clear_req  in  1  start a clear sweep, sampled in IDLE only
- busy  out  1  clear sweep in progress

## Operation
- FSM states: CLEAR, IDLE.
- Reset forces state CLEAR with sweep pointer 0. If CLEAR_WORDS = 0, reset forces IDLE instead.
- Reset values:
  - ready = 0 (1 if CLEAR_WORDS = 0)
  - busy = 1 (0 if CLEAR_WORDS = 0)
  - rvalid = 0, rdata = 0, read pipeline empty
- Array contents are not reset. Only the sweep zeroes them.
- CLEAR:
  - Each cycle writes 0 to mem[ptr] and increments ptr.
  - After writing address CLEAR_WORDS-1, the FSM moves to IDLE.
  - ready = 0 and busy = 1 throughout.
  - clear_req is ignored in this state.
- IDLE:
  - ready = 1, busy = 0.
  - An accepted write (req && we) stores wdata to mem[addr] at the edge.
  - An accepted read (req && !we) enters the read pipeline.
  - clear_req = 1 moves the FSM to CLEAR with ptr = 0 at the next edge.
  - A request accepted in the same cycle as clear_req is still executed.
- Reads are fully pipelined: one accept per cycle, responses returned in order, no stalls.
- Reads already in flight complete normally across an IDLE→CLEAR transition.
- Read-after-write to the same address in consecutive cycles returns the new data. One access per cycle means no same-cycle collision exists.
- Reset mid-sweep restarts the sweep from address 0. Reset mid-read drops the pending rvalid.

## Timing
- Write: data is in the array at the accepting edge; no response is generated.
- Read, READ_LATENCY = 1: rvalid and rdata are registered, valid the cycle after accept.
- Read, READ_LATENCY = 2: one extra output register; valid two cycles after accept.
- rdata holds its last value when rvalid = 0.
- Sweep duration: exactly CLEAR_WORDS cycles with busy = 1, from the first rising edge after reset release or after the clear_req edge.
- ready rises in the cycle after the last clear write.

## Structure
- Package pico_mem_pkg holds:
  - the state enum (CLEAR, IDLE)
  - the READ_LATENCY legality constants
  - an elaboration-time check function for CLEAR_WORDS <= 2**ADDR_WIDTH
- Sub-module pico_mem_array: plain synchronous RAM carrying the ram_init_file attribute from FILE_NAME.
  - One write port and a registered read port; no reset on the array.
  - Write input is muxed by the controller between the sweep and the CPU.
- The controller holds the FSM, sweep pointer, read-valid shift register, and optional second data stage.

## Test plan
- Reset release, CLEAR_WORDS = 8, array preloaded with 0xFFFF:
  - busy = 1 for 8 cycles, then ready = 1.
  - Reading addr 0..7 returns 0x0000; addr 8 returns 0xFFFF.
- Write 0x1234 to addr 5, then read addr 5 in the next cycle, READ_LATENCY = 1 → rvalid one cycle later with rdata = 0x1234.
- READ_LATENCY = 2, back-to-back reads of addr 1, 2, 3 holding 0xA, 0xB, 0xC → rvalid high for 3 consecutive cycles starting 2 cycles after the first accept, data 0xA, 0xB, 0xC.
- In IDLE, assert clear_req in the same cycle as an accepted read of addr 3 holding 0x00FF:
  - The read returns 0x00FF.
  - ready = 0 for 8 cycles.
  - A subsequent read of addr 3 returns 0x0000.
- rst_n asserted at sweep cycle 4 → after release the sweep restarts at address 0 and lasts 8 full cycles; rvalid = 0 throughout.
- CLEAR_WORDS = 0 → ready = 1 immediately after reset; the array retains init-file contents.

Source files
------------

// File: rtl/pico_mem_pkg.sv
// Shared types and elaboration-time checks for the pico memory controller.
package pico_mem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  localparam int unsigned RL_MIN = 1;
  localparam int unsigned RL_MAX = 2;

  // The sweep must not run past the top of the array.
  function automatic bit clear_words_ok(input int unsigned cw, input int unsigned aw);
    return cw <= (32'd1 << aw);
  endfunction

endpackage

// File: rtl/pico_memory_ctrl_array.sv
// Synchronous single-port RAM: one write port, registered read, no reset on storage.
module pico_mem_array #(
  parameter     FILE_NAME  = "mem_init.mif",
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  (* ram_init_file = FILE_NAME *) logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/pico_memory_ctrl.sv
// Memory controller: clear-sweep FSM, CPU request arbitration and read pipeline.
module pico_memory_ctrl
  import pico_mem_pkg::*;
#(
  parameter     FILE_NAME    = "mem_init.mif",
  parameter int ADDR_WIDTH   = 6,
  parameter int DATA_WIDTH   = 16,
  parameter int CLEAR_WORDS  = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  ready,
  output logic                  rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic                  clear_req,
  output logic                  busy
);

  if (!clear_words_ok(CLEAR_WORDS, ADDR_WIDTH)) begin : g_bad_clear_words
    $error("CLEAR_WORDS exceeds array depth");
  end
  if (READ_LATENCY < RL_MIN || READ_LATENCY > RL_MAX) begin : g_bad_latency
    $error("READ_LATENCY must be 1 or 2");
  end

  localparam bit                    NO_SWEEP = (CLEAR_WORDS == 0);
  localparam logic [ADDR_WIDTH-1:0] LAST     = ADDR_WIDTH'(CLEAR_WORDS - 1);

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   ptr;
  logic                    acc, rd, arr_we;
  logic [ADDR_WIDTH-1:0]   arr_addr;
  logic [DATA_WIDTH-1:0]   arr_wdata, rd_q;
  logic [READ_LATENCY:1]   vld_pipe;

  assign acc = req & ready;
  assign rd  = acc & ~we;

  // The sweep owns the write port while in CLEAR; ready is low then, so no CPU access competes.
  assign arr_we    = (state == CLEAR) | (acc & we);
  assign arr_addr  = (state == CLEAR) ? ptr : addr;
  assign arr_wdata = (state == CLEAR) ? '0 : wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= NO_SWEEP ? IDLE : CLEAR;
      ptr   <= '0;
      ready <= NO_SWEEP;
      busy  <= !NO_SWEEP;
    end else begin
      case (state)
        CLEAR: begin
          ptr <= ptr + 1'b1;
          if (ptr == LAST) begin
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end
        end
        IDLE: begin
          if (clear_req && !NO_SWEEP) begin
            state <= CLEAR;
            ptr   <= '0;
            ready <= 1'b0;
            busy  <= 1'b1;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe <= '0;
    else        vld_pipe <= READ_LATENCY'({vld_pipe, rd});
  end

  assign rvalid = vld_pipe[READ_LATENCY];

  pico_mem_array #(
    .FILE_NAME (FILE_NAME),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .re   (rd),
    .addr (arr_addr),
    .wdata(arr_wdata),
    .rdata(rd_q)
  );

  if (READ_LATENCY == 1) begin : g_lat1
    // The RAM read register has no reset; mask it until a read has been accepted.
    logic rd_seen;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  rd_seen <= 1'b0;
      else if (rd) rd_seen <= 1'b1;
    end
    assign rdata = rd_seen ? rd_q : '0;
  end else begin : g_lat2
    logic [DATA_WIDTH-1:0] dout_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)           dout_q <= '0;
      else if (vld_pipe[1]) dout_q <= rd_q;
    end
    assign rdata = dout_q;
  end

endmodule

// File: tb/tb_pico_memory_ctrl.sv
// Scoreboard bench: DUT 0 sweeps 8 words with latency 1, DUT 1 has no sweep and latency 2.
module tb_pico_memory_ctrl;

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic [1:0]  rst_n, req, we, clear_req, rdy, rvalid, busy;
  logic [5:0]  addr_v  [2];
  logic [15:0] wdata_v [2];
  logic [15:0] rdata_v [2];

  exp_t q0[$];
  exp_t q1[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pico_memory_ctrl #(.ADDR_WIDTH(6), .DATA_WIDTH(16), .CLEAR_WORDS(8), .READ_LATENCY(1)) dut0 (
    .clk(clk), .rst_n(rst_n[0]), .req(req[0]), .we(we[0]), .addr(addr_v[0]),
    .wdata(wdata_v[0]), .ready(rdy[0]), .rvalid(rvalid[0]), .rdata(rdata_v[0]),
    .clear_req(clear_req[0]), .busy(busy[0])
  );

  pico_memory_ctrl #(.ADDR_WIDTH(6), .DATA_WIDTH(16), .CLEAR_WORDS(0), .READ_LATENCY(2)) dut1 (
    .clk(clk), .rst_n(rst_n[1]), .req(req[1]), .we(we[1]), .addr(addr_v[1]),
    .wdata(wdata_v[1]), .ready(rdy[1]), .rvalid(rvalid[1]), .rdata(rdata_v[1]),
    .clear_req(clear_req[1]), .busy(busy[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one access at a negedge; a read accepted here is due RL cycles later.
  task automatic op(input int d, input bit w, input logic [5:0] a, input logic [15:0] wd,
                    input logic [15:0] exp_rd, input bit clr);
    exp_t e;
    req[d] = 1'b1; we[d] = w; addr_v[d] = a; wdata_v[d] = wd; clear_req[d] = clr;
    check($sformatf("ready_dut%0d", d), {31'd0, rdy[d]}, 32'd1);
    if (!w && rdy[d]) begin
      e.data = exp_rd;
      e.due  = cyc + (d == 0 ? 1 : 2);
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
    @(negedge clk);
    req[d] = 1'b0; clear_req[d] = 1'b0;
  endtask

  // Count cycles (sampled at negedges) that a flag stays at level lvl, bounded.
  task automatic count_level(input int d, input bit use_busy, input bit lvl, output int n);
    n = 0;
    while (((use_busy ? busy[d] : rdy[d]) == lvl) && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rvalid[0]) begin
      if (q0.size() == 0) check("unexpected_rvalid_dut0", 32'd1, 32'd0);
      else begin
        e = q0.pop_front();
        check("rdata_dut0", {16'd0, rdata_v[0]}, {16'd0, e.data});
        check("latency_dut0", cyc, e.due);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rvalid[1]) begin
      if (q1.size() == 0) check("unexpected_rvalid_dut1", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        check("rdata_dut1", {16'd0, rdata_v[1]}, {16'd0, e.data});
        check("latency_dut1", cyc, e.due);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation timed out at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst_n = 2'b00; req = '0; we = '0; clear_req = '0;
    for (int i = 0; i < 2; i++) begin addr_v[i] = '0; wdata_v[i] = '0; end
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_ready_dut0",  {31'd0, rdy[0]},    32'd0);
    check("rst_busy_dut0",   {31'd0, busy[0]},   32'd1);
    check("rst_rvalid_dut0", {31'd0, rvalid[0]}, 32'd0);
    check("rst_rdata_dut0",  {16'd0, rdata_v[0]}, 32'd0);
    check("rst_ready_dut1",  {31'd0, rdy[1]},    32'd1);
    check("rst_busy_dut1",   {31'd0, busy[1]},   32'd0);
    check("rst_rdata_dut1",  {16'd0, rdata_v[1]}, 32'd0);

    // Initial sweep: exactly 8 busy cycles, then ready
    rst_n = 2'b11;
    count_level(0, 1'b1, 1'b1, n);
    check("sweep_len_reset", n, 8);
    check("ready_after_sweep", {31'd0, rdy[0]}, 32'd1);

    // Fill 0..8 with 0xFFFF, put 0x00FF at 3
    for (int i = 0; i <= 8; i++) op(0, 1'b1, 6'(i), 16'hFFFF, 16'h0, 1'b0);
    op(0, 1'b1, 6'd3, 16'h00FF, 16'h0, 1'b0);
    // Read with clear_req in the same cycle: read completes, then 8-cycle sweep
    op(0, 1'b0, 6'd3, 16'h0, 16'h00FF, 1'b1);
    count_level(0, 1'b0, 1'b0, n);
    check("sweep_len_clear_req", n, 8);
    for (int i = 0; i <= 8; i++) op(0, 1'b0, 6'(i), 16'h0, (i == 8) ? 16'hFFFF : 16'h0000, 1'b0);

    // Read-after-write, latency 1
    op(0, 1'b1, 6'd5, 16'h1234, 16'h0, 1'b0);
    op(0, 1'b0, 6'd5, 16'h0, 16'h1234, 1'b0);

    // Reset at sweep cycle 4 restarts a full 8-cycle sweep
    op(0, 1'b1, 6'd7, 16'hBEEF, 16'h0, 1'b0);
    clear_req[0] = 1'b1;
    @(negedge clk);
    clear_req[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n[0] = 1'b0;
    @(negedge clk);
    check("midsweep_rst_busy", {31'd0, busy[0]}, 32'd1);
    check("midsweep_rst_ready", {31'd0, rdy[0]}, 32'd0);
    @(negedge clk);
    rst_n[0] = 1'b1;
    count_level(0, 1'b1, 1'b1, n);
    check("sweep_len_restart", n, 8);
    op(0, 1'b0, 6'd7, 16'h0, 16'h0000, 1'b0);
    op(0, 1'b0, 6'd8, 16'h0, 16'hFFFF, 1'b0);

    // Latency 2: back-to-back reads give 3 consecutive responses
    op(1, 1'b1, 6'd1, 16'h000A, 16'h0, 1'b0);
    op(1, 1'b1, 6'd2, 16'h000B, 16'h0, 1'b0);
    op(1, 1'b1, 6'd3, 16'h000C, 16'h0, 1'b0);
    op(1, 1'b0, 6'd1, 16'h0, 16'h000A, 1'b0);
    op(1, 1'b0, 6'd2, 16'h0, 16'h000B, 1'b0);
    op(1, 1'b0, 6'd3, 16'h0, 16'h000C, 1'b0);
    repeat (2) @(negedge clk);
    check("rdata_hold_dut1", {16'd0, rdata_v[1]}, 32'h000C);
    check("rvalid_idle_dut1", {31'd0, rvalid[1]}, 32'd0);
    check("busy_nosweep_dut1", {31'd0, busy[1]}, 32'd0);
    op(1, 1'b1, 6'd9, 16'h55AA, 16'h0, 1'b0);
    op(1, 1'b0, 6'd9, 16'h0, 16'h55AA, 1'b0);
    repeat (3) @(negedge clk);

    // Reset mid-read drops the pending response
    op(1, 1'b0, 6'd1, 16'h0, 16'h000A, 1'b0);
    rst_n[1] = 1'b0;
    q1.delete();
    repeat (3) @(negedge clk);
    check("rst_midread_rdata_dut1", {16'd0, rdata_v[1]}, 32'd0);
    check("rst_midread_ready_dut1", {31'd0, rdy[1]}, 32'd1);
    rst_n[1] = 1'b1;

    repeat (4) @(negedge clk);
    check("scoreboard_drained_dut0", q0.size(), 0);
    check("scoreboard_drained_dut1", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
